rifl_axis_upsizer: RTL

//  AXI-Stream width upsizer: packs RATIO narrow input beats into one wide output beat.

---
 rtl/rifl_axis_upsizer_if.sv | 21 ++
 rtl/rifl_axis_upsizer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rifl_axis_upsizer_if.sv
//------------------------------------------------------------------------------
// Module : rifl_axis_upsizer_if
// Brief  : AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready) of width DWIDTH.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rifl_axis_upsizer_if #(
    parameter int DWIDTH = 32
) ();
    logic [DWIDTH-1:0]   tdata;
    logic [DWIDTH/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/rifl_axis_upsizer.sv
//------------------------------------------------------------------------------
// Module : rifl_axis_upsizer
// Brief  : AXI-Stream width upsizer packing RATIO narrow beats into one wide beat,
//          lane 0 in the LSBs; tlast flushes short words. Optional input skid
//          buffer enabled by defining RIFL_UPSIZER_SKID_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rifl_axis_upsizer #(
    parameter int DWIDTH_IN = 32,
    parameter int RATIO     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rifl_axis_upsizer_if.slave    s_axis,
    rifl_axis_upsizer_if.master   m_axis
);
    localparam int DWIDTH_OUT = DWIDTH_IN * RATIO;
    localparam int KW_IN      = DWIDTH_IN / 8;
    localparam int KW_OUT     = DWIDTH_OUT / 8;
    localparam int IDX_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

    generate
        if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
            $error("rifl_axis_upsizer: RATIO must be a power of two >= 2");
        end
        if (DWIDTH_IN % 8 != 0 || DWIDTH_IN < 8) begin : g_bad_width
            $error("rifl_axis_upsizer: DWIDTH_IN must be a non-zero multiple of 8");
        end
    endgenerate

    // Beat presented to the packing core (directly from s_axis or from the skid head)
    logic                 w_core_valid;
    logic                 w_core_ready;
    logic [DWIDTH_IN-1:0] w_core_data;
    logic [KW_IN-1:0]     w_core_keep;
    logic                 w_core_last;

`ifdef RIFL_UPSIZER_SKID_EN
    logic [DWIDTH_IN-1:0] r_skid_data [2];
    logic [KW_IN-1:0]     r_skid_keep [2];
    logic                 r_skid_last [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic [1:0]           w_count_nxt;
    logic                 r_s_ready;
    logic                 w_push;
    logic                 w_pop;

    assign w_push       = s_axis.tvalid & r_s_ready;
    assign w_pop        = w_core_valid & w_core_ready;
    assign w_core_valid = (r_count != 2'd0);
    assign w_core_data  = r_skid_data[r_rd_ptr];
    assign w_core_keep  = r_skid_keep[r_rd_ptr];
    assign w_core_last  = r_skid_last[r_rd_ptr];
    assign s_axis.tready = r_s_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Ready is registered from the next occupancy so it never depends on m_axis.tready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_skid_data[r_wr_ptr] <= s_axis.tdata;
                r_skid_keep[r_wr_ptr] <= s_axis.tkeep;
                r_skid_last[r_wr_ptr] <= s_axis.tlast;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt != 2'd2);
        end
    end
`else
    assign w_core_valid  = s_axis.tvalid;
    assign w_core_data   = s_axis.tdata;
    assign w_core_keep   = s_axis.tkeep;
    assign w_core_last   = s_axis.tlast;
    assign s_axis.tready = w_core_ready;
`endif

    logic [IDX_W-1:0]      r_idx;
    logic [DWIDTH_OUT-1:0] r_m_data;
    logic [KW_OUT-1:0]     r_m_keep;
    logic                  r_m_last;
    logic                  r_m_valid;
    logic                  w_acc;
    logic                  w_null;
    logic                  w_write;
    logic                  w_complete;

    // The output register doubles as the assembly buffer; it is only free when not holding a word
    assign w_core_ready = ~r_m_valid | m_axis.tready;
    assign w_acc        = w_core_valid & w_core_ready;
    assign w_null       = (w_core_keep == '0) & ~w_core_last;
    assign w_write      = w_acc & ~w_null;
    assign w_complete   = w_write & ((r_idx == IDX_MAX) | w_core_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            if (r_m_valid & m_axis.tready) begin
                r_m_valid <= 1'b0;
            end
            if (w_complete) begin
                r_m_valid <= 1'b1;
                r_m_last  <= w_core_last;
            end
            if (w_write) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (IDX_W'(i) == r_idx) begin
                        r_m_data[i*DWIDTH_IN +: DWIDTH_IN] <= w_core_data;
                        r_m_keep[i*KW_IN +: KW_IN]         <= w_core_keep;
                    end else if (r_idx == '0) begin
                        r_m_keep[i*KW_IN +: KW_IN] <= '0;
                    end
                end
                r_idx <= w_complete ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign m_axis.tdata  = r_m_data;
    assign m_axis.tkeep  = r_m_keep;
    assign m_axis.tlast  = r_m_last;
    assign m_axis.tvalid = r_m_valid;

endmodule

`default_nettype wire
